conv_sched: RTL and testbench

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_sched.sv | 144 ++++++++++++++
 tb/tb_conv_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// conv_sched -- two requesters share one fixed-to-float converter.
//
// Each requester offers a signed 16-bit integer sample through a valid/ready
// handshake. A round-robin arbiter grants at most one sample per cycle. The
// granted sample passes through the single converter and is pushed into a
// 2-entry result FIFO. The FIFO head is presented through a valid/ready
// handshake on the output side.
//
// Converter format: the input is a two's-complement integer. The output is an
// IEEE-754 binary16 value. The mantissa is truncated toward zero. Every int16
// magnitude is within binary16 range, so the converter never saturates.
//
// Optional feature:
//   CONV_SCHED_CNT_EN -- when defined, adds the cnt0/cnt1 outputs. These count
//                        completed pops per requester and wrap at 16 bits.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req0_valid/data/ready    requester 0 handshake and sample
//   req1_valid/data/ready    requester 1 handshake and sample
//   out_valid/ready          result handshake
//   out_data, out_id         binary16 result and source requester at FIFO head
//   cnt0, cnt1               per-requester pop counts (CONV_SCHED_CNT_EN only)

module conv_fx2fp (
    input  logic [15:0] fixed_in,
    output logic [15:0] float_out
);
    logic        sgn;
    logic [15:0] mag;
    logic [3:0]  lead;
    logic [15:0] norm;

    always_comb begin
        sgn  = fixed_in[15];
        // -32768 negates to 16'h8000, which is still correct as an unsigned magnitude.
        mag  = sgn ? (~fixed_in + 16'd1) : fixed_in;
        lead = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) lead = 4'(i);
        end
        norm = mag << (4'd15 - lead);
        if (mag == 16'd0)
            float_out = 16'h0000;
        else
            float_out = {sgn, {1'b0, lead} + 5'd15, norm[14:5]};
    end
endmodule

module conv_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_id
`ifdef CONV_SCHED_CNT_EN
    ,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
`endif
);
    logic        last_gnt;
    logic [1:0]  count;
    logic        wptr;
    logic        rptr;
    logic [16:0] mem [2];

    logic        can_grant;
    logic        gnt0;
    logic        gnt1;
    logic        push;
    logic        pop;
    logic [15:0] conv_in;
    logic [15:0] conv_out;

    // rst_n is part of the grant condition so that both readys stay low while
    // reset is held. Without it, the cleared count would let a grant through.
    // Because the gate is combinational, a grant is still possible on the
    // first edge after release.
    assign can_grant = rst_n && (count != 2'd2);
    assign gnt0      = can_grant && req0_valid && (!req1_valid || last_gnt);
    assign gnt1      = can_grant && req1_valid && (!req0_valid || !last_gnt);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign push    = gnt0 || gnt1;
    assign conv_in = gnt1 ? req1_data : req0_data;

    conv_fx2fp u_conv (
        .fixed_in  (conv_in),
        .float_out (conv_out)
    );

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rptr][15:0] : 16'h0000;
    assign out_id    = out_valid ? mem[rptr][16]   : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            last_gnt <= 1'b1;
            mem[0]   <= 17'd0;
            mem[1]   <= 17'd0;
        end else begin
            if (push) begin
                mem[wptr] <= {gnt1, conv_out};
                wptr      <= ~wptr;
                last_gnt  <= gnt1;
            end
            if (pop)
                rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef CONV_SCHED_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else if (pop) begin
            if (out_id)
                cnt1 <= cnt1 + 16'd1;
            else
                cnt0 <= cnt0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;
    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_id;
`ifdef CONV_SCHED_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: the FIFO is a queue of {id, float}, plus the last winner.
    logic [16:0] q[$];
    logic        last_m;
    int          cnt_m[2];

    conv_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
`ifdef CONV_SCHED_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer to binary16 with truncation, computed arithmetically.
    function automatic logic [15:0] ref_conv(input logic [15:0] x);
        int v, mag, p, mant;
        logic s;
        v = int'($signed(x));
        s = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return 16'h0000;
        p = 0;
        while ((1 << (p + 1)) <= mag) p++;
        mant = ((mag - (1 << p)) * 1024) / (1 << p);
        return {s, 5'(p + 15), 10'(mant)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_m = 1'b1;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
    endtask

    // Called at a negedge. Drives inputs, checks outputs against the model,
    // advances the model, and returns at the next negedge.
    task automatic step(input logic v0, input logic [15:0] d0,
                        input logic v1, input logic [15:0] d1, input logic ordy);
        logic e0, e1;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        out_ready  = ordy;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (q.size() < 2) begin
            if (v0 && v1) begin
                if (last_m) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        chk("req0_ready", {15'd0, req0_ready}, {15'd0, e0});
        chk("req1_ready", {15'd0, req1_ready}, {15'd0, e1});
        chk("out_valid", {15'd0, out_valid}, {15'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0][15:0]);
            chk("out_id", {15'd0, out_id}, {15'd0, q[0][16]});
        end
`ifdef CONV_SCHED_CNT_EN
        chk("cnt0", cnt0, 16'(cnt_m[0]));
        chk("cnt1", cnt1, 16'(cnt_m[1]));
`endif
        if (q.size() != 0 && ordy) begin
            cnt_m[q[0][16]] = (cnt_m[q[0][16]] + 1) % 65536;
            void'(q.pop_front());
        end
        if (e0) begin q.push_back({1'b0, ref_conv(d0)}); last_m = 1'b0; end
        if (e1) begin q.push_back({1'b1, ref_conv(d1)}); last_m = 1'b1; end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h1234;
        req1_valid = 1'b1; req1_data = 16'h4321;
        out_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_id", {15'd0, out_id}, 16'd0);
        chk("rst_req0_ready", {15'd0, req0_ready}, 16'd0);
        chk("rst_req1_ready", {15'd0, req1_ready}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single stream from requester 0, 1-cycle latency.
        step(1'b1, 16'h4000, 1'b0, 16'h0, 1'b1);
        chk("ss0_data", out_data, 16'h7400);
        chk("ss0_id", {15'd0, out_id}, 16'd0);
        step(1'b1, 16'hC000, 1'b0, 16'h0, 1'b1);
        chk("ss1_data", out_data, 16'hF400);
        step(1'b1, 16'h0001, 1'b0, 16'h0, 1'b1);
        chk("ss2_data", out_data, 16'h3C00);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        chk("ss_drain", {15'd0, out_valid}, 16'd0);

        // Boundary conversions.
        step(1'b1, 16'h8000, 1'b0, 16'h0, 1'b1);
        chk("conv_min", out_data, 16'hF800);
        step(1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
        chk("conv_zero", out_data, 16'h0000);
        step(1'b0, 16'h0, 1'b1, 16'h7FFF, 1'b1);
        chk("conv_max", out_data, 16'h77FF);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

        // Contention: grants alternate.
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'(i * 37), 1'b1, 16'(16'hF000 + i), 1'b1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

        // Backpressure: two accepts, stall, then drain and resume.
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'(100 + i), 1'b1, 16'(200 + i), 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'(300 + i), 1'b1, 16'(400 + i), 1'b1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) != 0));

        // Reset mid-stream with two entries queued.
        step(1'b1, 16'h0111, 1'b1, 16'h0222, 1'b0);
        step(1'b1, 16'h0333, 1'b1, 16'h0444, 1'b0);
        chk("pre_rst_full", {15'd0, out_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_out_data", out_data, 16'h0000);
        chk("mid_rst_req0_ready", {15'd0, req0_ready}, 16'd0);
        chk("mid_rst_req1_ready", {15'd0, req1_ready}, 16'd0);
`ifdef CONV_SCHED_CNT_EN
        chk("mid_rst_cnt0", cnt0, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 16'h0010, 1'b1, 16'h0020, 1'b1);
        chk("post_rst_id", {15'd0, out_id}, 16'd0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1);

        // Per-requester pop counts after a fresh reset.
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++)
            step(1'b0, 16'h0, 1'b1, 16'(i + 1), 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'(i + 9), 1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
`ifdef CONV_SCHED_CNT_EN
        chk("cnt1_five", cnt1, 16'd5);
        chk("cnt0_three", cnt0, 16'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
